dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Sequencing and arbitration controller in front of the word-wide data memory of the RISC-V core. It shares the single-port data memory between the core load/store path and a word-wide loader/debug port, using round-robin arbitration. It converts RV32 byte/half/word loads and stores into word reads and read-modify-write cycles. Sub-word load results are returned sign- or zero-extended. It sits between the core's memory stage, the loader, and the data memory instance.

## Interface
- mem_depth, 1024, memory depth in words; word index width AW = $clog2(mem_depth)
- size, 32, word width in bits; fixed at 32 for RV32 sub-word handling
- clock  in  1  single clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- core_req  in  1  core access request; held with fields until core_gnt
- core_we  in  1  1 = store, 0 = load
- core_funct3  in  3  RV32 funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- core_addr  in  size  byte address; word index = core_addr[AW+1:2], bits above ignored
- core_wdata  in  size  store data; byte/half taken from LSBs
- core_gnt  out  1  combinational grant; request latched on this edge
- core_rvalid  out  1  one-cycle completion pulse, for loads and stores
- core_rdata  out  size  extended load data; 0 for stores and errors
- core_err  out  1  valid with core_rvalid: misaligned or illegal funct3
- ld_req  in  1  loader request, full-word only
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  AW  word address
- ld_wdata  in  size  write data
- ld_gnt  out  1  combinational grant
- ld_rvalid  out  1  one-cycle completion pulse
- ld_rdata  out  size  read word; 0 for writes
- mem_address  out  AW  to data memory address
- mem_data_in  out  size  to data memory write data
- mem_wren  out  1  to data memory write enable
- mem_data_out  in  size  from data memory; combinational read of mem_address

## Operation
- FSM states:
  - IDLE: arbitrate and latch the winning request.
  - READ: drive the latched word index with mem_wren=0, and capture mem_data_out into word_buf.
  - WRITE: stores only; assert mem_wren=1 and drive mem_data_in with the merged word.
  - RESP: loads and errors; pulse rvalid.
- State transitions:
  - IDLE→READ on any grant.
  - READ→WRITE for a legal store.
  - READ→RESP for a load or an error.
  - WRITE→IDLE, with rvalid pulsed during WRITE.
  - RESP→IDLE.
- Arbitration happens only in IDLE:
  - If only one port requests, it wins.
  - If both request, the port not granted last wins. The last-grant register resets to loader, so the core wins the first tie.
  - Both gnt outputs are 0 outside IDLE.
- Core address checks:
  - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0.
  - Illegal funct3: loads 011/110/111; stores with funct3 ≥ 011.
  - Either case flows READ→RESP with core_err=1 and core_rdata=0. No write occurs.
- Load extraction is little-endian:
  - Byte select = addr[1:0]; half select = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store merge: word_buf with only the addressed byte lane (SB) or half lane (SH) replaced by the LSBs of core_wdata. SW replaces the whole word.
- Loader accesses are full-word; the loader never errors.
- mem_address = latched word index in READ and WRITE, 0 in IDLE.
- mem_data_in = merged word in WRITE, else 0.
- mem_wren is asserted only in WRITE.

## Timing
- Grant in cycle T, when gnt=1 and the request is latched at the T edge.
- READ occurs in T+1.
- rvalid pulses in T+2 (WRITE or RESP); the memory write commits at the end of T+2.
- The next grant is possible in T+3. Maximum throughput is one access per 3 cycles.
- rdata/err are registered and valid only while rvalid=1; otherwise 0.
- Requesters hold req and all fields stable until gnt. The request may be dropped or changed from T+1 on.
- Reset values, forced immediately on reset_n low:
  - State IDLE, last-grant = loader, word_buf = 0.
  - All rvalid/err/rdata = 0.
  - mem_wren = 0, mem_address = 0, mem_data_in = 0.
  - Both gnt = 0 while reset_n is low.
- Reset asserted mid-access (READ or WRITE): the access is abandoned. No mem_wren pulse and no rvalid for it, even in the WRITE cycle, because mem_wren drops asynchronously.
- A simultaneous new request during an rvalid cycle is not granted until IDLE (T+3).

## Test plan
- Core SW 0xDEADBEEF @0x10, then LW @0x10 → mem_wren in store T+2 with mem_address 4; load core_rdata 0xDEADBEEF, core_err 0.
- Word @0x20 = 0x8081_7F01; LB @0x22 → 0xFFFFFF81; LBU @0x22 → 0x00000081; LH @0x22 → 0xFFFF8081; LHU @0x20 → 0x00007F01.
- SB 0x55 @0x21 onto 0x11223344 → memory word 0x11225544; SH 0xABCD @0x22 → 0xABCD5544.
- LW @0x02 or SH @0x03, or funct3 011 → core_rvalid with core_err=1, core_rdata 0, no mem_wren during the access.
- core_req and ld_req held high continuously, both issuing loads → grants alternate core, loader, core, with a grant every 3 cycles.
- reset_n pulled low during the WRITE cycle of SW 0x12345678 @0x0 → memory word 0 unchanged, no rvalid, FSM in IDLE after reset release.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: round-robin shares one word-wide memory port between
// the core load/store path and the loader, turning sub-word stores into read-modify-write.
module dmem_access_ctrl #(
    parameter int mem_depth = 1024,
    parameter int size      = 32,
    localparam int AW       = $clog2(mem_depth)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [2:0]      core_funct3,
    input  logic [size-1:0] core_addr,
    input  logic [size-1:0] core_wdata,
    output logic            core_gnt,
    output logic            core_rvalid,
    output logic [size-1:0] core_rdata,
    output logic            core_err,
    input  logic            ld_req,
    input  logic            ld_we,
    input  logic [AW-1:0]   ld_addr,
    input  logic [size-1:0] ld_wdata,
    output logic            ld_gnt,
    output logic            ld_rvalid,
    output logic [size-1:0] ld_rdata,
    output logic [AW-1:0]   mem_address,
    output logic [size-1:0] mem_data_in,
    output logic            mem_wren,
    input  logic [size-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_last_core;
    logic            r_is_core;
    logic            r_we;
    logic            r_err;
    logic [2:0]      r_funct3;
    logic [1:0]      r_byte_sel;
    logic [AW-1:0]   r_widx;
    logic [size-1:0] r_wdata;
    logic [size-1:0] r_word_buf;
    logic            r_core_rvalid;
    logic            r_core_err;
    logic [size-1:0] r_core_rdata;
    logic            r_ld_rvalid;
    logic [size-1:0] r_ld_rdata;
    logic            w_idle;
    logic            w_core_win;
    logic            w_ld_win;
    logic            w_core_gnt;
    logic            w_ld_gnt;
    logic            w_unused_addr;

    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lo);
        logic e;
        e = 1'b1;
        case (f3)
            3'b000:  e = 1'b0;
            3'b001:  e = lo[0];
            3'b010:  e = (lo != 2'b00);
            3'b100:  e = we;
            3'b101:  e = we | lo[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [size-1:0] load_extract(input logic [size-1:0] word,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] lo);
        logic [size-1:0] sh;
        logic [7:0]      b;
        logic [15:0]     h;
        logic [size-1:0] r;
        sh = word >> {lo, 3'b000};
        b  = sh[7:0];
        h  = lo[1] ? word[31:16] : word[15:0];
        r  = {size{1'b0}};
        case (f3)
            3'b000:  r = {{(size-8){b[7]}}, b};
            3'b001:  r = {{(size-16){h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {{(size-8){1'b0}}, b};
            3'b101:  r = {{(size-16){1'b0}}, h};
            default: r = {size{1'b0}};
        endcase
        return r;
    endfunction

    function automatic logic [size-1:0] store_merge(input logic [size-1:0] word,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] lo,
                                                    input logic [size-1:0] wd);
        logic [size-1:0] m;
        m = word;
        case (f3)
            3'b000:  m[{lo, 3'b000} +: 8] = wd[7:0];
            3'b001:  m[{lo[1], 4'b0000} +: 16] = wd[15:0];
            3'b010:  m = wd;
            default: m = word;
        endcase
        return m;
    endfunction

    // Grants only in IDLE and never while reset is held; ties go to the port not served last.
    assign w_idle        = reset_n && (r_state == ST_IDLE);
    assign w_core_win    = core_req && (!ld_req || !r_last_core);
    assign w_ld_win      = ld_req && !w_core_win;
    assign w_core_gnt    = w_idle && w_core_win;
    assign w_ld_gnt      = w_idle && w_ld_win;
    assign core_gnt      = w_core_gnt;
    assign ld_gnt        = w_ld_gnt;
    assign w_unused_addr = &{1'b0, core_addr[size-1:AW+2]};

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_core_gnt || w_ld_gnt) begin
                    w_next_state = ST_READ;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_READ: begin
                if (r_we && !r_err) begin
                    w_next_state = ST_WRITE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            ST_WRITE: w_next_state = ST_IDLE;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Latch the winning request; loader accesses are treated as aligned full-word ops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_core <= 1'b0;
            r_is_core   <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_funct3    <= 3'b000;
            r_byte_sel  <= 2'b00;
            r_widx      <= {AW{1'b0}};
            r_wdata     <= {size{1'b0}};
        end else if (w_core_gnt) begin
            r_last_core <= 1'b1;
            r_is_core   <= 1'b1;
            r_we        <= core_we;
            r_err       <= access_err(core_we, core_funct3, core_addr[1:0]);
            r_funct3    <= core_funct3;
            r_byte_sel  <= core_addr[1:0];
            r_widx      <= core_addr[AW+1:2];
            r_wdata     <= core_wdata;
        end else if (w_ld_gnt) begin
            r_last_core <= 1'b0;
            r_is_core   <= 1'b0;
            r_we        <= ld_we;
            r_err       <= 1'b0;
            r_funct3    <= 3'b010;
            r_byte_sel  <= 2'b00;
            r_widx      <= ld_addr;
            r_wdata     <= ld_wdata;
        end
    end

    // Capture the addressed word during READ for the merge in WRITE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_word_buf <= {size{1'b0}};
        end else if (r_state == ST_READ) begin
            r_word_buf <= mem_data_out;
        end
    end

    // Completion pulses and read data, launched at the end of READ so they appear with WRITE/RESP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_core_rvalid <= 1'b0;
            r_core_err    <= 1'b0;
            r_core_rdata  <= {size{1'b0}};
            r_ld_rvalid   <= 1'b0;
            r_ld_rdata    <= {size{1'b0}};
        end else if (r_state == ST_READ) begin
            r_core_rvalid <= r_is_core;
            r_core_err    <= r_is_core && r_err;
            r_core_rdata  <= (r_is_core && !r_we && !r_err) ?
                             load_extract(mem_data_out, r_funct3, r_byte_sel) : {size{1'b0}};
            r_ld_rvalid   <= !r_is_core;
            r_ld_rdata    <= (!r_is_core && !r_we) ? mem_data_out : {size{1'b0}};
        end else begin
            r_core_rvalid <= 1'b0;
            r_core_err    <= 1'b0;
            r_core_rdata  <= {size{1'b0}};
            r_ld_rvalid   <= 1'b0;
            r_ld_rdata    <= {size{1'b0}};
        end
    end

    assign core_rvalid = r_core_rvalid;
    assign core_err    = r_core_err;
    assign core_rdata  = r_core_rdata;
    assign ld_rvalid   = r_ld_rvalid;
    assign ld_rdata    = r_ld_rdata;

    // Memory-side drive, decoded from registered state so wren falls as soon as reset asserts.
    always_comb begin
        mem_address = {AW{1'b0}};
        mem_data_in = {size{1'b0}};
        mem_wren    = 1'b0;
        case (r_state)
            ST_READ: begin
                mem_address = r_widx;
            end
            ST_WRITE: begin
                mem_address = r_widx;
                mem_data_in = store_merge(r_word_buf, r_funct3, r_byte_sel, r_wdata);
                mem_wren    = 1'b1;
            end
            default: begin
                mem_address = {AW{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: behavioural memory plus a byte-addressed reference model.
module tb_dmem_access_ctrl;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          core_req, core_we, core_gnt, core_rvalid, core_err;
    logic [2:0]    core_funct3;
    logic [31:0]   core_addr, core_wdata, core_rdata;
    logic          ld_req, ld_we, ld_gnt, ld_rvalid;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata, ld_rdata;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_data_in, mem_data_out;
    logic          mem_wren;
    logic          mem_clear;

    logic [31:0] mem [0:DEPTH-1];
    logic [7:0]  ref_mem [0:4*DEPTH-1];
    int total = 0;
    int bad   = 0;

    dmem_access_ctrl #(.mem_depth(DEPTH), .size(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_wren(mem_wren),
        .mem_data_out(mem_data_out)
    );

    always #5 clock = ~clock;

    assign mem_data_out = mem[mem_address];

    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else if (mem_wren) begin
            mem[mem_address] <= mem_data_in;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int nb(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int base;
        base = int'(a[11:0]);
        if (f3[1:0] == 2'd3) return 1'b1;
        if (we && f3[2]) return 1'b1;
        if (f3 == 3'd6) return 1'b1;
        return (base % nb(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        longint v;
        int n, base;
        v = 0;
        n = nb(f3);
        base = int'(a[11:0]);
        for (int i = 0; i < n; i++) v += longint'(ref_mem[base + i]) << (8 * i);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_word(input int idx);
        longint v;
        v = 0;
        for (int i = 0; i < 4; i++) v += longint'(ref_mem[4 * idx + i]) << (8 * i);
        return v[31:0];
    endfunction

    task automatic ref_store(input int base, input int n, input logic [31:0] wd);
        for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(wd >> (8 * i));
    endtask

    task automatic core_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er);
        logic        e;
        logic [31:0] exp_rd;
        int          n, idx;
        e      = ref_err(we, f3, a);
        exp_rd = (we || e) ? 32'd0 : ref_load(f3, a);
        idx    = int'(a[11:2]);
        rd     = 32'd0;
        er     = 1'b0;
        @(negedge clock);
        core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = a; core_wdata = wd;
        #1;
        n = 0;
        while (!core_gnt && n < 20) begin @(negedge clock); #1; n++; end
        chk("core_gnt", 32'(core_gnt), 32'd1);
        if (!core_gnt) begin core_req = 1'b0; return; end
        @(posedge clock); #1;
        core_req = 1'b0; core_addr = $urandom; core_wdata = $urandom; core_funct3 = 3'($urandom);
        @(negedge clock);
        chk("core_t1_rvalid", 32'(core_rvalid), 32'd0);
        chk("core_t1_wren", 32'(mem_wren), 32'd0);
        chk("core_t1_addr", 32'(mem_address), 32'(idx));
        @(negedge clock);
        chk("core_t2_rvalid", 32'(core_rvalid), 32'd1);
        chk("core_t2_err", 32'(core_err), 32'(e));
        chk("core_t2_rdata", core_rdata, exp_rd);
        chk("core_t2_ldrvalid", 32'(ld_rvalid), 32'd0);
        chk("core_t2_wren", 32'(mem_wren), 32'(we && !e));
        if (we && !e) begin
            ref_store(int'(a[11:0]), nb(f3), wd);
            chk("core_t2_waddr", 32'(mem_address), 32'(idx));
            chk("core_t2_wdata", mem_data_in, ref_word(idx));
        end
        rd = core_rdata;
        er = core_err;
        @(negedge clock);
        chk("core_t3_rvalid", 32'(core_rvalid), 32'd0);
        chk("core_mem_word", mem[idx], ref_word(idx));
    endtask

    task automatic ld_op(input logic we, input int idx, input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] exp_rd;
        int n;
        exp_rd = we ? 32'd0 : ref_word(idx);
        rd = 32'd0;
        @(negedge clock);
        ld_req = 1'b1; ld_we = we; ld_addr = AW'(idx); ld_wdata = wd;
        #1;
        n = 0;
        while (!ld_gnt && n < 20) begin @(negedge clock); #1; n++; end
        chk("ld_gnt", 32'(ld_gnt), 32'd1);
        if (!ld_gnt) begin ld_req = 1'b0; return; end
        @(posedge clock); #1;
        ld_req = 1'b0; ld_addr = AW'($urandom); ld_wdata = $urandom;
        @(negedge clock);
        chk("ld_t1_rvalid", 32'(ld_rvalid), 32'd0);
        chk("ld_t1_addr", 32'(mem_address), 32'(idx));
        @(negedge clock);
        chk("ld_t2_rvalid", 32'(ld_rvalid), 32'd1);
        chk("ld_t2_rdata", ld_rdata, exp_rd);
        chk("ld_t2_corervalid", 32'(core_rvalid), 32'd0);
        chk("ld_t2_wren", 32'(mem_wren), 32'(we));
        if (we) begin
            ref_store(4 * idx, 4, wd);
            chk("ld_t2_wdata", mem_data_in, wd);
        end
        rd = ld_rdata;
        @(negedge clock);
        chk("ld_mem_word", mem[idx], ref_word(idx));
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        int          n;
        for (int i = 0; i < 4 * DEPTH; i++) ref_mem[i] = 8'd0;
        reset_n = 1'b0; mem_clear = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'd0; core_wdata = 32'd0;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_wdata = 32'd0;
        @(negedge clock); @(negedge clock);
        chk("rst_core_gnt", 32'(core_gnt), 32'd0);
        chk("rst_ld_gnt", 32'(ld_gnt), 32'd0);
        chk("rst_rvalid", {30'd0, core_rvalid, ld_rvalid}, 32'd0);
        chk("rst_rdata", core_rdata | ld_rdata, 32'd0);
        chk("rst_mem_ctrl", {mem_data_in[31:1], mem_data_in[0] | mem_wren}, 32'd0);
        chk("rst_mem_addr", 32'(mem_address), 32'd0);
        mem_clear = 1'b0; core_req = 1'b0; ld_req = 1'b0; reset_n = 1'b1;

        core_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
        core_op(1'b0, 3'b010, 32'h10, 32'd0, rd, er);
        chk("lw_deadbeef", rd, 32'hDEADBEEF);
        chk("lw_deadbeef_err", 32'(er), 32'd0);

        ld_op(1'b1, 8, 32'h8081_7F01, rd);
        core_op(1'b0, 3'b000, 32'h22, 32'd0, rd, er); chk("lb_0x22", rd, 32'hFFFFFF81);
        core_op(1'b0, 3'b100, 32'h22, 32'd0, rd, er); chk("lbu_0x22", rd, 32'h00000081);
        core_op(1'b0, 3'b001, 32'h22, 32'd0, rd, er); chk("lh_0x22", rd, 32'hFFFF8081);
        core_op(1'b0, 3'b101, 32'h20, 32'd0, rd, er); chk("lhu_0x20", rd, 32'h00007F01);

        ld_op(1'b1, 8, 32'h1122_3344, rd);
        core_op(1'b1, 3'b000, 32'h21, 32'h0000_0055, rd, er); chk("sb_word", mem[8], 32'h11225544);
        core_op(1'b1, 3'b001, 32'h22, 32'h0000_ABCD, rd, er); chk("sh_word", mem[8], 32'hABCD5544);
        ld_op(1'b0, 8, 32'd0, rd); chk("ld_read_word", rd, 32'hABCD5544);

        core_op(1'b0, 3'b010, 32'h02, 32'd0, rd, er); chk("lw_mis_err", 32'(er), 32'd1);
        core_op(1'b1, 3'b001, 32'h03, 32'hFFFF, rd, er); chk("sh_mis_err", 32'(er), 32'd1);
        chk("sh_mis_nowrite", mem[0], 32'd0);
        core_op(1'b0, 3'b011, 32'h10, 32'd0, rd, er); chk("f3_011_err", 32'(er), 32'd1);
        chk("f3_011_rdata", rd, 32'd0);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                ld_op(1'($urandom), int'($urandom_range(0, 63)), $urandom, rd);
            end else begin
                a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
                core_op(1'($urandom), 3'($urandom), a, $urandom, rd, er);
            end
        end

        // Reset during the WRITE cycle of a store abandons it.
        @(negedge clock);
        core_req = 1'b1; core_we = 1'b1; core_funct3 = 3'b010; core_addr = 32'h0; core_wdata = 32'h12345678;
        #1;
        n = 0;
        while (!core_gnt && n < 20) begin @(negedge clock); #1; n++; end
        chk("rstw_gnt", 32'(core_gnt), 32'd1);
        @(posedge clock); #1; core_req = 1'b0;
        @(negedge clock); @(negedge clock);
        chk("rstw_wren_before", 32'(mem_wren), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstw_wren_async", 32'(mem_wren), 32'd0);
        chk("rstw_rvalid_async", 32'(core_rvalid), 32'd0);
        @(negedge clock);
        chk("rstw_rvalid", 32'(core_rvalid), 32'd0);
        chk("rstw_mem0", mem[0], ref_word(0));
        reset_n = 1'b1;

        // Both ports loading continuously: grants every third cycle, core first.
        core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h40; ld_we = 1'b0; ld_addr = AW'(5);
        core_req = 1'b1; ld_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("arb_core_c%0d", c), 32'(core_gnt), 32'((c % 3 == 0) && ((c / 3) % 2 == 0)));
            chk($sformatf("arb_ld_c%0d", c), 32'(ld_gnt), 32'((c % 3 == 0) && ((c / 3) % 2 == 1)));
            @(negedge clock);
        end
        core_req = 1'b0; ld_req = 1'b0;
        @(negedge clock); @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
